imem_loader: RTL and testbench

Boot-time program loader for the single-cycle MIPS core. It receives a byte-serial program image over a valid/ready stream and writes it word-by-word into the instruction memory through that memory's write port. It holds the processor stalled until an image has loaded with a correct checksum. It is the writer on the instruction-memory interface that the core only reads.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/byte_packer.sv | 41 ++++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Imported by the loader top and its byte packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs four stream bytes into a little-endian word.
// word/word_ready are valid in the cycle the 4th byte is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam int IW = $clog2(WORD_BYTES);

  logic [IW-1:0] idx_q;
  logic [23:0]   buf_q;

  assign word_ready = en && (idx_q == IW'(WORD_BYTES - 1));
  assign word       = {byte_in, buf_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (en) begin
      idx_q <= idx_q + 1'b1;
      unique case (idx_q)
        2'd0:    buf_q[7:0]   <= byte_in;
        2'd1:    buf_q[15:8]  <= byte_in;
        2'd2:    buf_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory writes.
// Holds the core until an image with a good checksum has loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int CW = ADDR_W + 1;

  state_e        state_q, state_d;
  logic          acc;
  logic          restart;
  logic          pk_en;
  logic          last_word;
  logic          len_bad;
  logic [15:0]   len_full;
  logic [7:0]    len_lo_q;
  logic [CW-1:0] len_q;
  logic [7:0]    chk_q;
  logic [31:0]   pk_word;
  logic          pk_ready;

  assign rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI)
                 || (state_q == S_DATA)   || (state_q == S_CHECK);
  assign cpu_hold = (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);

  assign acc     = rx_valid && rx_ready;
  assign restart = start && ((state_q == S_IDLE)
                          || (state_q == S_DONE)
                          || (state_q == S_ERR));
  assign pk_en   = acc && (state_q == S_DATA);

  // Length compared as a plain 16-bit count against 2^ADDR_W.
  assign len_full = {rx_data, len_lo_q};
  assign len_bad  = (len_full == 16'd0)
                 || (32'(len_full) > (32'd1 << ADDR_W));

  assign last_word = pk_ready && ((word_count + CW'(1)) == len_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (restart),
    .en         (pk_en),
    .byte_in    (rx_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_d = S_LEN_LO;
      S_LEN_LO:
        if (acc) state_d = S_LEN_HI;
      S_LEN_HI:
        if (acc) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA:
        if (last_word) state_d = S_CHECK;
      S_CHECK:
        if (acc) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      chk_q      <= '0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        word_count <= '0;
        chk_q      <= '0;
      end
      if (acc && state_q == S_LEN_LO) len_lo_q <= rx_data;
      if (acc && state_q == S_LEN_HI) len_q <= len_full[CW-1:0];
      if (pk_en) chk_q <= chk_q ^ rx_data;
      // word_count doubles as the write index; it stops at N.
      if (pk_ready) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= pk_word;
        word_count <= word_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader.
// Reference model: image rules, expected write list and flags.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] img [0:1023];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;

  imem_loader #(.ADDR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      wr_t w;
      w.addr = int'(imem_addr);
      w.data = imem_wdata;
      got_q.push_back(w);
      check("wc_with_we", 32'(word_count), 32'(imem_addr) + 1);
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    t = 0;
    forever begin
      start = gaps && ($urandom_range(0, 15) == 0);
      if (gaps && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready) begin
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
      t++;
      if (t > 100) begin
        check("rx_ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] n,
                          input logic [7:0]  flip,
                          input bit          gaps);
    logic [7:0] cs;
    logic [7:0] b;
    bit         len_ok;
    bit         ok;
    int         c0;
    int         m;
    wr_t        w;
    cs     = 8'd0;
    len_ok = (n != 16'd0) && (int'(n) <= 1024);
    ok     = len_ok && (flip == 8'd0);
    exp_q.delete();
    pulse_start();
    got_q.delete();
    c0 = cyc;
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(error), 32'd0);
    check("start_wc", 32'(word_count), 32'd0);
    check("start_rdy", 32'(rx_ready), 32'd1);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    if (len_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 0; k < 4; k++) begin
          b  = img[i][8*k +: 8];
          cs = cs ^ b;
          send_byte(b, gaps);
        end
        w.addr = i;
        w.data = img[i];
        exp_q.push_back(w);
      end
      send_byte(cs ^ flip, gaps);
    end
    start = 1'b0;
    if (!gaps)
      check("cycles", 32'(cyc - c0), len_ok ? 32'(4 * int'(n) + 3) : 32'd2);
    check("end_done", 32'(done), 32'(ok));
    check("end_err", 32'(error), 32'(!ok));
    check("end_hold", 32'(cpu_hold), 32'(!ok));
    check("end_rdy", 32'(rx_ready), 32'd0);
    check("end_wc", 32'(word_count), len_ok ? 32'(n) : 32'd0);
    check("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check("wr_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check("wr_data", got_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    reset = 1'b1;

    img[0] = 32'h2008_0013;
    img[1] = 32'h0000_002A;
    run_load(16'd2, 8'h00, 1'b0);
    run_load(16'd2, 8'h11, 1'b0);
    run_load(16'd0, 8'h00, 1'b0);
    run_load(16'h0401, 8'h00, 1'b0);
    run_load(16'hFFFF, 8'h00, 1'b1);
    run_load(16'd2, 8'h00, 1'b1);

    // Reset after five payload bytes.
    pulse_start();
    got_q.delete();
    send_byte(8'd2, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(img[k / 4][8*(k % 4) +: 8], 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(rx_ready), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_nwr", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      check("mid_rst_addr", 32'(got_q[0].addr), 32'd0);
      check("mid_rst_data", got_q[0].data, img[0]);
    end
    reset = 1'b1;

    run_load(16'd2, 8'h00, 1'b0);
    img[0] = 32'hDEAD_BEEF;
    run_load(16'd1, 8'h00, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      run_load(16'(n),
               ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    run_load(16'd1024, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
